// File: rtl/cu_seq_pkg.sv
// cu_seq shared definitions: opcodes, sub-ops, ALU selects, states.
// Optional feature macro: CU_ILLEGAL_TRAP_EN (see cu_seq.sv).
package cu_seq_pkg;

  localparam logic [2:0] cu_lda        = 3'b000;
  localparam logic [2:0] cu_add        = 3'b001;
  localparam logic [2:0] cu_sta        = 3'b010;
  localparam logic [2:0] cu_ban        = 3'b011;
  localparam logic [2:0] cu_jmp        = 3'b100;
  localparam logic [2:0] cu_long_begin = 3'b111;

  localparam logic [4:0] cu_cla  = 5'b00000;
  localparam logic [4:0] cu_com  = 5'b00001;
  localparam logic [4:0] cu_shr  = 5'b00010;
  localparam logic [4:0] cu_csl  = 5'b00011;
  localparam logic [4:0] cu_stop = 5'b00100;

  localparam logic [2:0] ACC_PASS = 3'b000;
  localparam logic [2:0] ACC_ADD  = 3'b001;
  localparam logic [2:0] ACC_CLR  = 3'b010;
  localparam logic [2:0] ACC_NOT  = 3'b011;
  localparam logic [2:0] ACC_SHR  = 3'b100;
  localparam logic [2:0] ACC_CSL  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_HALT   = 3'd5
  } cu_state_t;

  // Encodings with no defined behaviour: two spare opcodes, high sub-ops.
  function automatic logic cu_is_illegal(
    input logic [2:0] op,
    input logic [4:0] sub
  );
    return (op == 3'b101) || (op == 3'b110) ||
           ((op == cu_long_begin) && (sub > cu_stop));
  endfunction

endpackage

// File: rtl/cu_seq.sv
// cu_seq: accumulator-machine control sequencer (fetch/decode/memory).
// Macro CU_ILLEGAL_TRAP_EN: illegal encodings halt and raise sticky illegal.
module cu_seq
  import cu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] ir_op,
  input  logic [4:0] ir_sub,
  input  logic       acc_neg,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       pc_clr,
  output logic       acc_load,
  output logic [2:0] acc_op,
  output logic       busy,
  output logic       halted,
  output logic       illegal
);

  cu_state_t r_state;
  cu_state_t w_next;
  logic      w_trap;

  // Next state and output decode; everything forced low while in reset.
  always_comb begin
    w_next   = r_state;
    w_trap   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    pc_clr   = 1'b0;
    acc_load = 1'b0;
    acc_op   = ACC_PASS;
    busy     = 1'b0;
    halted   = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            pc_clr = 1'b1;
            w_next = S_FETCH;
          end
        end
        S_FETCH: begin
          busy    = 1'b1;
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            w_next  = S_DECODE;
          end
        end
        S_DECODE: begin
          busy   = 1'b1;
          w_next = S_FETCH;
          case (ir_op)
            cu_lda, cu_add: w_next = S_MEM_RD;
            cu_sta:         w_next = S_MEM_WR;
            cu_jmp:         pc_load = 1'b1;
            cu_ban:         pc_load = acc_neg;
            cu_long_begin: begin
              case (ir_sub)
                cu_cla: begin
                  acc_load = 1'b1;
                  acc_op   = ACC_CLR;
                end
                cu_com: begin
                  acc_load = 1'b1;
                  acc_op   = ACC_NOT;
                end
                cu_shr: begin
                  acc_load = 1'b1;
                  acc_op   = ACC_SHR;
                end
                cu_csl: begin
                  acc_load = 1'b1;
                  acc_op   = ACC_CSL;
                end
                cu_stop: w_next = S_HALT;
                default: w_trap = 1'b1;
              endcase
            end
            default: w_trap = 1'b1;
          endcase
`ifdef CU_ILLEGAL_TRAP_EN
          if (w_trap)
            w_next = S_HALT;
`endif
        end
        S_MEM_RD: begin
          busy     = 1'b1;
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (mem_ack) begin
            acc_load = 1'b1;
            acc_op   = (ir_op == cu_add) ? ACC_ADD : ACC_PASS;
            w_next   = S_FETCH;
          end
        end
        S_MEM_WR: begin
          busy     = 1'b1;
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          if (mem_ack)
            w_next = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
          if (start) begin
            pc_clr = 1'b1;
            w_next = S_FETCH;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky trap flag; a restart from HALT clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_illegal <= 1'b0;
    else if (pc_clr)
      r_illegal <= 1'b0;
    else if (r_state == S_DECODE &&
             cu_is_illegal(ir_op, ir_sub))
      r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cu_seq.sv
// cu_seq bench: random instruction stream expanded to per-cycle expectations.
// Also checks asynchronous reset during a pending memory read.
module tb_cu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] ir_op;
  logic [4:0] ir_sub;
  logic       acc_neg;
  logic       mem_ack;
  logic       mem_req, mem_we, addr_sel;
  logic       ir_load, pc_inc, pc_load, pc_clr, acc_load;
  logic [2:0] acc_op;
  logic       busy, halted, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ir_op(ir_op), .ir_sub(ir_sub),
    .acc_neg(acc_neg), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_clr(pc_clr), .acc_load(acc_load),
    .acc_op(acc_op), .busy(busy),
    .halted(halted), .illegal(illegal)
  );

  // {req,we,asel,irl,pinc,pld,pclr,accl,aop[3],busy,halted,ill}
  logic [13:0] w_got;
  assign w_got = {mem_req, mem_we, addr_sel, ir_load,
                  pc_inc, pc_load, pc_clr, acc_load,
                  acc_op, busy, halted, illegal};

  typedef struct {
    logic        s;
    logic [2:0]  op;
    logic [4:0]  sub;
    logic        neg;
    logic        ack;
    logic [13:0] exp;
  } cyc_t;

  cyc_t q[$];

  task automatic chk(input string tag,
                     input logic [13:0] got,
                     input logic [13:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] ev(
    input logic req, input logic we, input logic asel,
    input logic irl, input logic pinc, input logic pld,
    input logic pclr, input logic accl,
    input logic [2:0] aop, input logic bsy,
    input logic hlt, input logic ill);
    return {req, we, asel, irl, pinc, pld, pclr, accl,
            aop, bsy, hlt, ill};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic s, input logic [2:0] o,
                      input logic [4:0] sb, input logic n,
                      input logic a, input logic [13:0] e);
    cyc_t c;
    c.s = s; c.op = o; c.sub = sb;
    c.neg = n; c.ack = a; c.exp = e;
    q.push_back(c);
  endtask

  // Expand one instruction into the cycles the controller must show.
  task automatic add_instr(input logic [2:0] op,
                           input logic [4:0] sub,
                           input logic neg,
                           input int df, input int dm);
    logic [13:0] dec;
    logic [2:0]  aop;
    bit          bad, halt, trap;
    int          mem;
    int          hc;
    mem  = 0;
    halt = 0;
    trap = 0;
    for (int k = 0; k < df; k++)
      push(rb(), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
           rb(), 1'b0, ev(1,0,0,0,0,0,0,0,3'd0,1,0,0));
    push(rb(), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
         rb(), 1'b1, ev(1,0,0,1,1,0,0,0,3'd0,1,0,0));
    bad = (op == 3'd5) || (op == 3'd6) ||
          (op == 3'd7 && sub > 5'd4);
    dec = ev(0,0,0,0,0,0,0,0,3'd0,1,0,0);
    if (op == 3'd0 || op == 3'd1) mem = 1;
    else if (op == 3'd2) mem = 2;
    else if (op == 3'd4) dec = ev(0,0,0,0,0,1,0,0,3'd0,1,0,0);
    else if (op == 3'd3) dec = ev(0,0,0,0,0,neg,0,0,3'd0,1,0,0);
    else if (op == 3'd7 && sub < 5'd4) begin
      aop = sub[2:0] + 3'd2;
      dec = ev(0,0,0,0,0,0,0,1,aop,1,0,0);
    end else if (op == 3'd7 && sub == 5'd4) halt = 1;
`ifdef CU_ILLEGAL_TRAP_EN
    if (bad) begin
      halt = 1;
      trap = 1;
    end
`endif
    push(rb(), op, sub, neg, rb(), dec);
    if (mem != 0) begin
      for (int k = 0; k < dm; k++)
        push(rb(), op, sub, neg, 1'b0,
             ev(1,(mem == 2),1,0,0,0,0,0,3'd0,1,0,0));
      aop = (op == 3'd1) ? 3'd1 : 3'd0;
      if (mem == 1)
        push(rb(), op, sub, neg, 1'b1,
             ev(1,0,1,0,0,0,0,1,aop,1,0,0));
      else
        push(rb(), op, sub, neg, 1'b1,
             ev(1,1,1,0,0,0,0,0,3'd0,1,0,0));
    end
    if (halt) begin
      hc = $urandom_range(1, 3);
      for (int k = 0; k < hc; k++)
        push(1'b0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
             rb(), rb(), ev(0,0,0,0,0,0,0,0,3'd0,0,1,trap));
      push(1'b1, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
           rb(), rb(), ev(0,0,0,0,0,0,1,0,3'd0,0,1,trap));
    end
  endtask

  task automatic drive(input cyc_t c);
    start   = c.s;
    ir_op   = c.op;
    ir_sub  = c.sub;
    acc_neg = c.neg;
    mem_ack = c.ack;
  endtask

  logic [13:0] zero = '0;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b1;
    ir_op   = 3'd0;
    ir_sub  = 5'd0;
    acc_neg = 1'b0;
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("reset", w_got, zero);
    @(negedge clk);
    rst_n   = 1'b1;
    start   = 1'b0;

    // Idle with stray ack, then start.
    push(1'b0, 3'd0, 5'd0, 1'b0, 1'b1, zero);
    push(1'b0, 3'd2, 5'd0, 1'b1, 1'b0, zero);
    push(1'b1, 3'd0, 5'd0, 1'b0, 1'b0,
         ev(0,0,0,0,0,0,1,0,3'd0,0,0,0));
    add_instr(3'd0, 5'd0, 1'b0, 0, 0);
    add_instr(3'd2, 5'd0, 1'b0, 0, 4);
    add_instr(3'd3, 5'd0, 1'b1, 1, 0);
    add_instr(3'd3, 5'd0, 1'b0, 0, 0);
    add_instr(3'd4, 5'd0, 1'b1, 2, 0);
    add_instr(3'd1, 5'd0, 1'b0, 0, 1);
    add_instr(3'd7, 5'd3, 1'b0, 0, 0);
    add_instr(3'd7, 5'd2, 1'b0, 0, 0);
    add_instr(3'd7, 5'd1, 1'b0, 0, 0);
    add_instr(3'd7, 5'd0, 1'b0, 0, 0);
    add_instr(3'd7, 5'd4, 1'b0, 0, 0);
    add_instr(3'd5, 5'd0, 1'b0, 0, 0);
    add_instr(3'd6, 5'd0, 1'b1, 0, 0);
    add_instr(3'd7, 5'd9, 1'b0, 1, 0);
    for (int i = 0; i < 60; i++)
      add_instr(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                rb(), $urandom_range(0, 2), $urandom_range(0, 3));

    foreach (q[i]) begin
      @(negedge clk);
      drive(q[i]);
      #1 chk($sformatf("cyc%0d", i), w_got, q[i].exp);
    end

    // Fresh run: reset while a read waits for ack.
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    #1 chk("rst_start", w_got, ev(0,0,0,0,0,0,1,0,3'd0,0,0,0));
    @(negedge clk);
    start = 1'b0;
    mem_ack = 1'b1;
    ir_op = 3'd0;
    #1 chk("rst_fetch", w_got, ev(1,0,0,1,1,0,0,0,3'd0,1,0,0));
    @(negedge clk);
    mem_ack = 1'b0;
    #1 chk("rst_dec", w_got, ev(0,0,0,0,0,0,0,0,3'd0,1,0,0));
    @(negedge clk);
    #1 chk("rst_rdwait", w_got, ev(1,0,1,0,0,0,0,0,3'd0,1,0,0));
    #2 rst_n = 1'b0;
    mem_ack = 1'b1;
    #1 chk("rst_async", w_got, zero);
    @(negedge clk);
    #1 chk("rst_hold", w_got, zero);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("rst_idle%0d", k), w_got, zero);
    end
    @(negedge clk);
    start = 1'b1;
    mem_ack = 1'b0;
    #1 chk("rst_restart", w_got, ev(0,0,0,0,0,0,1,0,3'd0,0,0,0));
    @(negedge clk);
    start = 1'b0;
    #1 chk("rst_fetch2", w_got, ev(1,0,0,0,0,0,0,0,3'd0,1,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cu_seq.md
CU_SEQ -- requirements
Module: cu_seq

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL have ports: start  in  1  begin execution from address 0 (IDLE or HALT only).
REQ-004 SHALL have ports: ir_op  in  3  opcode field of instruction register; ir_sub  in  5  sub-op field (long instructions).
REQ-005 SHALL have ports: acc_neg  in  1  accumulator sign bit; mem_ack  in  1  memory transfer done.
REQ-006 SHALL have ports: mem_req  out  1; mem_we  out  1; addr_sel  out  1  (0 = PC, 1 = IR address field).
REQ-007 SHALL have ports: ir_load, pc_inc, pc_load, pc_clr, acc_load  out  1 each  single-cycle datapath strobes.
REQ-008 SHALL have ports: acc_op  out  3  ALU select; busy, halted, illegal  out  1 each  status.

Function
REQ-009 SHALL implement states IDLE, FETCH, DECODE, MEM_RD, MEM_WR, HALT; every output is a decode of state, ir fields, acc_neg and mem_ack.
REQ-010 IDLE: start=1 -> pc_clr=1 that cycle, next FETCH; otherwise stay.
REQ-011 FETCH: mem_req=1, mem_we=0, addr_sel=0 held until mem_ack; ack cycle -> ir_load=1, pc_inc=1, next DECODE.
REQ-012 DECODE (exactly one cycle): lda/add -> MEM_RD; sta -> MEM_WR; jmp -> pc_load=1, next FETCH; ban -> pc_load=acc_neg, next FETCH.
REQ-013 DECODE, long_begin: cla/com/shr/csl -> acc_load=1 with acc_op CLR/NOT/SHR/CSL, next FETCH; stop -> HALT.
REQ-014 MEM_RD: mem_req=1, addr_sel=1, mem_we=0 until ack; ack cycle -> acc_load=1, acc_op PASS (lda) or ADD (add), next FETCH.
REQ-015 MEM_WR: mem_req=1, mem_we=1, addr_sel=1 until ack; ack cycle -> next FETCH.
REQ-016 mem_ack SHALL be ignored when mem_req=0; mem_req/addr_sel/mem_we SHALL stay stable from assertion to ack.
REQ-017 HALT: halted=1; start=1 -> pc_clr=1, next FETCH, halted drops next cycle.
REQ-018 busy=1 in FETCH, DECODE, MEM_RD, MEM_WR; start ignored while busy.
REQ-019 Latency with zero-wait ack: lda/add/sta 3 cycles, jmp/ban/long 2 cycles, fetch-to-fetch.
REQ-020 acc_op SHALL be 3'b000 whenever acc_load=0.

Reset
REQ-021 rst_n low SHALL force state IDLE and all outputs 0 asynchronously, including mid-transfer (mem_req drops immediately).
REQ-022 After rst_n rises, first action SHALL occur only on start.

Configuration
REQ-023 Macro CU_ILLEGAL_TRAP_EN defined: opcodes 3'b101/3'b110 or long sub-op > 5'b00100 in DECODE -> HALT, illegal=1 sticky until reset or restart via start.
REQ-024 Macro CU_ILLEGAL_TRAP_EN undefined: same encodings execute as NOP (DECODE -> FETCH, no strobes); illegal tied 0.

Structure
REQ-025 Shared package/include SHALL hold opcodes: cu_lda 000, cu_add 001, cu_sta 010, cu_ban 011, cu_jmp 100, cu_long_begin 111.
REQ-026 Same package SHALL hold sub-ops cu_cla 00000, cu_com 00001, cu_shr 00010, cu_csl 00011, cu_stop 00100, plus acc_op codes PASS 000, ADD 001, CLR 010, NOT 011, SHR 100, CSL 101, and state encodings.
REQ-027 Single module, no sub-modules; next-state and output decode in one file.

Verification
REQ-028 Reset, start, fetch lda (ir_op 000), ack same cycle -> pc_clr, FETCH (ir_load+pc_inc), DECODE, MEM_RD (acc_load, acc_op 000); 3 cycles.
REQ-029 sta with ack delayed 4 cycles -> mem_req=1, mem_we=1, addr_sel=1 stable 5 cycles; return to FETCH on ack.
REQ-030 ban with acc_neg=1 -> pc_load=1 in DECODE; acc_neg=0 -> pc_load=0; both return to FETCH.
REQ-031 long csl, shr, com, cla, then stop -> acc_op 101/100/011/010 with acc_load; stop -> halted=1, busy=0; start -> pc_clr, FETCH.
REQ-032 rst_n low during MEM_RD wait -> mem_req, busy 0 same cycle, state IDLE; stray mem_ack ignored.
REQ-033 ir_op 101 with CU_ILLEGAL_TRAP_EN -> HALT, illegal=1; without -> no strobes, next FETCH, illegal=0.
